sort_e3_merge: RTL and testbench

Final merge stage of the top-K sorter pipeline. It consumes the per-chunk candidates produced by the E2 stage: five high and five low entries per chunk, each already carrying a global index. It keeps a running global top-5 maximum list and top-5 minimum list across all chunks of a frame. On the frame's last chunk it streams the ten results to the downstream consumer through a valid/ready handshake.

---
 rtl/sort_e3_merge_pkg.sv | 37 +++
 rtl/sort_e3_merge_if.sv | 38 +++
 rtl/sort_e3_merge_topk_insert_list.sv | 52 +++++
 rtl/sort_e3_merge.sv | 207 ++++++++++++++++++++
 tb/tb_sort_e3_merge.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sort_e3_merge_pkg.sv
// Shared types and constants for the E3 merge stage of the top-K sorter.
// Entries are {index, data}; only the data field takes part in ordering.
package sort_e3_merge_pkg;

  localparam int Data_Width  = 8;
  localparam int Index_Width = 16;
  localparam int K           = 5;
  localparam int Entry_Width = Index_Width + Data_Width;
  localparam int Res_Count   = 2 * K;

  typedef struct packed {
    logic [Index_Width-1:0] index;
    logic [Data_Width-1:0]  data;
  } entry_t;

  typedef struct packed {
    logic   valid;
    entry_t entry;
  } slot_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MERGE,
    ST_DRAIN
  } state_t;

  typedef enum logic {
    MODE_MAX,
    MODE_MIN
  } mode_e;

  // Strict comparison, so on a tie the entry already in the list keeps its rank.
  function automatic logic beats(mode_e mode, entry_t cand, entry_t cur);
    return (mode == MODE_MAX) ? (cand.data > cur.data) : (cand.data < cur.data);
  endfunction

endpackage

// File: rtl/sort_e3_merge_if.sv
// Candidate input bus from E2 and the result stream to the downstream consumer.
interface sort_e3_merge_if;
  import sort_e3_merge_pkg::*;

  logic [Entry_Width-1:0] E2H_sorter_out0, E2H_sorter_out1, E2H_sorter_out2,
                          E2H_sorter_out3, E2H_sorter_out4;
  logic [Entry_Width-1:0] E2L_sorter_out0, E2L_sorter_out1, E2L_sorter_out2,
                          E2L_sorter_out3, E2L_sorter_out4;
  logic                   E2_sort_en;
  logic                   E2_last_sort;
  logic                   merge_busy;
  logic                   res_valid;
  logic                   res_ready;
  logic [Entry_Width-1:0] res_data;
  logic                   res_is_low;
  logic [2:0]             res_rank;
  logic                   res_empty;
  logic                   res_last;
  logic                   frame_done;
  logic                   overflow_err;

  modport slave (
    input  E2H_sorter_out0, E2H_sorter_out1, E2H_sorter_out2, E2H_sorter_out3, E2H_sorter_out4,
    input  E2L_sorter_out0, E2L_sorter_out1, E2L_sorter_out2, E2L_sorter_out3, E2L_sorter_out4,
    input  E2_sort_en, E2_last_sort, res_ready,
    output merge_busy, res_valid, res_data, res_is_low, res_rank, res_empty, res_last,
    output frame_done, overflow_err
  );

  modport master (
    output E2H_sorter_out0, E2H_sorter_out1, E2H_sorter_out2, E2H_sorter_out3, E2H_sorter_out4,
    output E2L_sorter_out0, E2L_sorter_out1, E2L_sorter_out2, E2L_sorter_out3, E2L_sorter_out4,
    output E2_sort_en, E2_last_sort, res_ready,
    input  merge_busy, res_valid, res_data, res_is_low, res_rank, res_empty, res_last,
    input  frame_done, overflow_err
  );

endinterface

// File: rtl/sort_e3_merge_topk_insert_list.sv
// Five-slot sorted register list; one candidate per cycle is inserted in rank
// order (MODE_MAX: descending, MODE_MIN: ascending). Rank K-1 falls off the end.
module topk_insert_list
  import sort_e3_merge_pkg::*;
#(
  parameter mode_e MODE = MODE_MAX
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             clr,
  input  logic             ins_en,
  input  entry_t           cand,
  output slot_t  [K-1:0]   slots_o,
  output slot_t  [K-1:0]   slots_nxt_o
);

  slot_t [K-1:0] slots_q, slots_d;
  logic  [K-1:0] take;
  slot_t         new_slot;

  // The list stays a valid prefix sorted by data, so take[] is a suffix of ones
  // and its first set bit is the insertion point.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    slots_d  = slots_q;
    take     = '0;
    new_slot = '{valid: 1'b1, entry: cand};
    for (int r = 0; r < K; r++) begin
      take[r] = !slots_q[r].valid || beats(MODE, cand, slots_q[r].entry);
    end
    if (clr) begin
      slots_d = '0;
    end else if (ins_en) begin
      if (take[0]) slots_d[0] = new_slot;
      for (int r = 1; r < K; r++) begin
        if (take[r]) slots_d[r] = take[r-1] ? slots_q[r-1] : new_slot;
      end
    end
  end

  // NOTE: the slots are reset like any flop; the valid bits must start cleared
  // and the array is only five entries, so it is not left to a RAM.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!sys_rst_n) slots_q <= '0;
    else            slots_q <= slots_d;
  end

  assign slots_o     = slots_q;
  assign slots_nxt_o = slots_d;

endmodule

// File: rtl/sort_e3_merge.sv
// E3 merge: folds each chunk's 5 high / 5 low candidates into running global
// top-5 max/min lists and streams the ten results on the frame's last chunk.
module sort_e3_merge
  import sort_e3_merge_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              sorter_clr,
  sort_e3_merge_if.slave    bus
);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  entry_t [K-1:0]  hold_h_q, hold_h_d, hold_l_q, hold_l_d, in_h, in_l;
  logic            last_q, last_d;
  logic [3:0]      out_idx_q, out_idx_d;
  logic            res_valid_q, res_valid_d;
  entry_t          res_q, res_d;
  logic            res_is_low_q, res_is_low_d;
  logic [2:0]      res_rank_q, res_rank_d;
  logic            res_empty_q, res_empty_d;
  logic            res_last_q, res_last_d;
  logic            frame_done_q, frame_done_d;
  logic            overflow_q, overflow_d;

  logic            merge_busy, res_hs, list_ins, list_clr, load_en, load_low;
  logic [3:0]      load_idx;
  logic [2:0]      load_rank;
  slot_t           load_slot;
  slot_t [K-1:0]   max_slots, max_nxt, min_slots, min_nxt;

  assign in_h[0] = bus.E2H_sorter_out0;
  assign in_h[1] = bus.E2H_sorter_out1;
  assign in_h[2] = bus.E2H_sorter_out2;
  assign in_h[3] = bus.E2H_sorter_out3;
  assign in_h[4] = bus.E2H_sorter_out4;
  assign in_l[0] = bus.E2L_sorter_out0;
  assign in_l[1] = bus.E2L_sorter_out1;
  assign in_l[2] = bus.E2L_sorter_out2;
  assign in_l[3] = bus.E2L_sorter_out3;
  assign in_l[4] = bus.E2L_sorter_out4;

  topk_insert_list #(.MODE(MODE_MAX)) u_max_list (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(list_clr), .ins_en(list_ins),
    .cand(hold_h_q[cnt_q]), .slots_o(max_slots), .slots_nxt_o(max_nxt)
  );

  topk_insert_list #(.MODE(MODE_MIN)) u_min_list (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .clr(list_clr), .ins_en(list_ins),
    .cand(hold_l_q[cnt_q]), .slots_o(min_slots), .slots_nxt_o(min_nxt)
  );

  assign res_hs = res_valid_q && bus.res_ready;

  // Result entries are loaded from the lists' next state so the first entry is
  // ready in the cycle right after the final insertion.
  assign load_idx  = (state_q == ST_DRAIN) ? out_idx_q + 4'd1 : 4'd0;
  assign load_low  = (load_idx >= 4'(K));
  assign load_rank = load_low ? 3'(load_idx - 4'(K)) : load_idx[2:0];
  assign load_slot = load_low ? min_nxt[load_rank] : max_nxt[load_rank];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (sorter_clr) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (bus.E2_sort_en) state_d = ST_MERGE;
        ST_MERGE: if (cnt_q == 3'(K-1)) state_d = last_q ? ST_DRAIN : ST_IDLE;
        ST_DRAIN: if (res_hs && out_idx_q == 4'(Res_Count-1)) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    merge_busy = (state_q != ST_IDLE);
  end

  always_comb begin
    hold_h_d     = hold_h_q;
    hold_l_d     = hold_l_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    out_idx_d    = out_idx_q;
    res_valid_d  = res_valid_q;
    res_d        = res_q;
    res_is_low_d = res_is_low_q;
    res_rank_d   = res_rank_q;
    res_empty_d  = res_empty_q;
    res_last_d   = res_last_q;
    overflow_d   = overflow_q;
    frame_done_d = 1'b0;
    list_ins     = 1'b0;
    list_clr     = 1'b0;
    load_en      = 1'b0;

    if (sorter_clr) begin
      hold_h_d     = '0;
      hold_l_d     = '0;
      last_d       = 1'b0;
      cnt_d        = '0;
      out_idx_d    = '0;
      res_valid_d  = 1'b0;
      res_d        = '0;
      res_is_low_d = 1'b0;
      res_rank_d   = '0;
      res_empty_d  = 1'b0;
      res_last_d   = 1'b0;
      overflow_d   = 1'b0;
      list_clr     = 1'b1;
    end else begin
      // A chunk offered while busy is dropped; only the sticky flag records it.
      if (bus.E2_sort_en && merge_busy) overflow_d = 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (bus.E2_sort_en) begin
            hold_h_d = in_h;
            hold_l_d = in_l;
            last_d   = bus.E2_last_sort;
            cnt_d    = '0;
          end
        end
        ST_MERGE: begin
          list_ins = 1'b1;
          cnt_d    = (cnt_q == 3'(K-1)) ? 3'd0 : cnt_q + 3'd1;
          if (cnt_q == 3'(K-1) && last_q) load_en = 1'b1;
        end
        ST_DRAIN: begin
          if (res_hs) begin
            if (out_idx_q == 4'(Res_Count-1)) begin
              res_valid_d  = 1'b0;
              res_d        = '0;
              res_is_low_d = 1'b0;
              res_rank_d   = '0;
              res_empty_d  = 1'b0;
              res_last_d   = 1'b0;
              list_clr     = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              load_en = 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (load_en) begin
        out_idx_d    = load_idx;
        res_valid_d  = 1'b1;
        res_d        = load_slot.valid ? load_slot.entry : '0;
        res_empty_d  = !load_slot.valid;
        res_is_low_d = load_low;
        res_rank_d   = load_rank;
        res_last_d   = (load_idx == 4'(Res_Count-1));
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hold_h_q     <= '0;
      hold_l_q     <= '0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
      out_idx_q    <= '0;
      res_valid_q  <= 1'b0;
      res_q        <= '0;
      res_is_low_q <= 1'b0;
      res_rank_q   <= '0;
      res_empty_q  <= 1'b0;
      res_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      hold_h_q     <= hold_h_d;
      hold_l_q     <= hold_l_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      out_idx_q    <= out_idx_d;
      res_valid_q  <= res_valid_d;
      res_q        <= res_d;
      res_is_low_q <= res_is_low_d;
      res_rank_q   <= res_rank_d;
      res_empty_q  <= res_empty_d;
      res_last_q   <= res_last_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.merge_busy   = merge_busy;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_q;
  assign bus.res_is_low   = res_is_low_q;
  assign bus.res_rank     = res_rank_q;
  assign bus.res_empty    = res_empty_q;
  assign bus.res_last     = res_last_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.overflow_err = overflow_q;

endmodule

// File: tb/tb_sort_e3_merge.sv
// Directed, table-driven bench for sort_e3_merge: frame vectors with
// hand-computed results, plus backpressure, overflow and clear sequences.
module tb_sort_e3_merge;
  import sort_e3_merge_pkg::*;

  typedef entry_t [K-1:0] chunk_t;

  typedef struct packed {
    logic [1:0]              nchunks;
    chunk_t [1:0]            h;
    chunk_t [1:0]            l;
    entry_t [Res_Count-1:0]  exp;
  } vec_t;

  logic sys_clk    = 1'b0;
  logic sys_rst_n  = 1'b0;
  logic sorter_clr = 1'b0;
  int   checks     = 0;
  int   passes     = 0;
  vec_t vecs [4];

  sort_e3_merge_if bus ();

  sort_e3_merge dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .sorter_clr(sorter_clr),
    .bus       (bus)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic entry_t mk(input int idx, input int d);
    mk = '{index: 16'(idx), data: 8'(d)};
  endfunction

  function automatic chunk_t mkc(input int d0, input int d1, input int d2, input int d3,
                                 input int d4, input int i0, input int i1, input int i2,
                                 input int i3, input int i4);
    mkc[0] = mk(i0, d0);
    mkc[1] = mk(i1, d1);
    mkc[2] = mk(i2, d2);
    mkc[3] = mk(i3, d3);
    mkc[4] = mk(i4, d4);
  endfunction

  function automatic entry_t [Res_Count-1:0] mke(input chunk_t mx, input chunk_t mn);
    for (int i = 0; i < K; i++) begin
      mke[i]     = mx[i];
      mke[K + i] = mn[i];
    end
  endfunction

  task automatic drive_chunk(input chunk_t h, input chunk_t l);
    bus.E2H_sorter_out0 = h[0]; bus.E2H_sorter_out1 = h[1]; bus.E2H_sorter_out2 = h[2];
    bus.E2H_sorter_out3 = h[3]; bus.E2H_sorter_out4 = h[4];
    bus.E2L_sorter_out0 = l[0]; bus.E2L_sorter_out1 = l[1]; bus.E2L_sorter_out2 = l[2];
    bus.E2L_sorter_out3 = l[3]; bus.E2L_sorter_out4 = l[4];
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after MERGE.
  // ovf_at >= 0 offers a junk chunk during that MERGE cycle.
  task automatic send_chunk(input chunk_t h, input chunk_t l, input logic last, input int ovf_at);
    int guard = 0;
    while (bus.merge_busy && guard < 100) begin
      @(negedge sys_clk);
      guard++;
    end
    check("idle_before_send", {31'd0, bus.merge_busy}, 32'd0);
    drive_chunk(h, l);
    bus.E2_sort_en   = 1'b1;
    bus.E2_last_sort = last;
    @(negedge sys_clk);
    bus.E2_sort_en   = 1'b0;
    bus.E2_last_sort = 1'b0;
    for (int k = 0; k < K; k++) begin
      check($sformatf("merge_cycle%0d_busy_valid", k), {30'd0, bus.merge_busy, bus.res_valid}, 32'd2);
      if (k == ovf_at) begin
        drive_chunk(mkc(255, 255, 255, 255, 255, 999, 999, 999, 999, 999),
                    mkc(0, 0, 0, 0, 0, 999, 999, 999, 999, 999));
        bus.E2_sort_en   = 1'b1;
        bus.E2_last_sort = 1'b1;
      end
      @(negedge sys_clk);
      bus.E2_sort_en   = 1'b0;
      bus.E2_last_sort = 1'b0;
    end
    check("after_merge_busy_valid", {30'd0, bus.merge_busy, bus.res_valid}, {30'd0, last, last});
  endtask

  // Collects n_hs handshakes, comparing each against exp; bp selects the 1,0,0,1 ready pattern.
  task automatic drain(input entry_t [Res_Count-1:0] exp, input logic bp, input int n_hs);
    int     got = 0;
    int     cyc = 0;
    logic   stalled = 1'b0;
    entry_t held = '0;
    while (got < n_hs && cyc < 300) begin
      bus.res_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled)
        check($sformatf("stall_hold%0d", got), {7'd0, bus.res_valid, bus.res_data}, {7'd0, 1'b1, held});
      stalled = bus.res_valid && !bus.res_ready;
      held    = bus.res_data;
      if (bus.res_valid && bus.res_ready) begin
        check($sformatf("res_data%0d", got), {8'd0, bus.res_data}, {8'd0, exp[got]});
        check($sformatf("res_flags%0d", got),
              {26'd0, bus.res_is_low, bus.res_rank, bus.res_empty, bus.res_last},
              {26'd0, 1'(got >= K), 3'(got % K), 1'b0, 1'(got == Res_Count - 1)});
        got++;
      end
      @(negedge sys_clk);
      cyc++;
    end
    bus.res_ready = 1'b0;
    check("drain_count", got, n_hs);
    if (n_hs == Res_Count) begin
      check("frame_done_pulse", {29'd0, bus.frame_done, bus.merge_busy, bus.res_valid}, 32'd4);
      @(negedge sys_clk);
      check("frame_done_one_cycle", {31'd0, bus.frame_done}, 32'd0);
    end
  endtask

  task automatic run_frame(input vec_t v, input logic bp);
    for (int c = 0; c < int'(v.nchunks); c++)
      send_chunk(v.h[c], v.l[c], (c == int'(v.nchunks) - 1), -1);
    drain(v.exp, bp, Res_Count);
  endtask

  initial begin
    int fd_seen;

    for (int v = 0; v < 4; v++) vecs[v] = '0;
    // Single chunk, index = data.
    vecs[0].nchunks = 2'd1;
    vecs[0].h[0] = mkc(90, 80, 70, 60, 50, 90, 80, 70, 60, 50);
    vecs[0].l[0] = mkc(1, 2, 3, 4, 5, 1, 2, 3, 4, 5);
    vecs[0].exp  = mke(mkc(90, 80, 70, 60, 50, 90, 80, 70, 60, 50),
                       mkc(1, 2, 3, 4, 5, 1, 2, 3, 4, 5));
    // Two chunks, interleaving ranks.
    vecs[1].nchunks = 2'd2;
    vecs[1].h[0] = mkc(90, 80, 70, 60, 50, 0, 1, 2, 3, 4);
    vecs[1].l[0] = mkc(10, 20, 30, 40, 50, 5, 6, 7, 8, 9);
    vecs[1].h[1] = mkc(95, 85, 10, 10, 10, 32, 33, 34, 35, 36);
    vecs[1].l[1] = mkc(5, 25, 200, 15, 35, 37, 38, 39, 40, 41);
    vecs[1].exp  = mke(mkc(95, 90, 85, 80, 70, 32, 0, 33, 1, 2),
                       mkc(5, 10, 15, 20, 25, 37, 5, 40, 6, 38));
    // Ties: earlier entries keep their ranks.
    vecs[2].nchunks = 2'd2;
    vecs[2].h[0] = mkc(50, 50, 50, 50, 50, 0, 1, 2, 3, 4);
    vecs[2].l[0] = mkc(7, 7, 7, 7, 7, 10, 11, 12, 13, 14);
    vecs[2].h[1] = mkc(50, 50, 50, 50, 50, 32, 33, 34, 35, 36);
    vecs[2].l[1] = mkc(7, 7, 7, 7, 7, 40, 41, 42, 43, 44);
    vecs[2].exp  = mke(mkc(50, 50, 50, 50, 50, 0, 1, 2, 3, 4),
                       mkc(7, 7, 7, 7, 7, 10, 11, 12, 13, 14));
    // Unsigned extremes, unsorted arrival order.
    vecs[3].nchunks = 2'd1;
    vecs[3].h[0] = mkc(0, 255, 128, 127, 1, 100, 101, 102, 103, 104);
    vecs[3].l[0] = mkc(255, 0, 128, 127, 1, 200, 201, 202, 203, 204);
    vecs[3].exp  = mke(mkc(255, 128, 127, 1, 0, 101, 102, 103, 104, 100),
                       mkc(0, 1, 127, 128, 255, 201, 204, 203, 202, 200));

    drive_chunk('0, '0);
    bus.E2_sort_en   = 1'b0;
    bus.E2_last_sort = 1'b0;
    bus.res_ready    = 1'b0;

    repeat (3) @(negedge sys_clk);
    check("reset_ctl", {24'd0, bus.merge_busy, bus.res_valid, bus.res_is_low, bus.res_rank,
                        bus.res_empty, bus.res_last, bus.frame_done, bus.overflow_err}, 32'd0);
    check("reset_data", {8'd0, bus.res_data}, 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    for (int v = 0; v < 4; v++) run_frame(vecs[v], 1'b0);
    check("no_overflow_yet", {31'd0, bus.overflow_err}, 32'd0);

    // Backpressure on the two-chunk frame.
    run_frame(vecs[1], 1'b1);

    // Chunk offered during the third MERGE cycle is dropped and flagged.
    send_chunk(vecs[0].h[0], vecs[0].l[0], 1'b1, 2);
    check("overflow_set", {31'd0, bus.overflow_err}, 32'd1);
    drain(vecs[0].exp, 1'b0, Res_Count);
    repeat (3) @(negedge sys_clk);
    check("overflow_sticky", {31'd0, bus.overflow_err}, 32'd1);

    // Clear after the fourth handshake, with a handshake pending on the same edge.
    send_chunk(vecs[0].h[0], vecs[0].l[0], 1'b1, -1);
    drain(vecs[0].exp, 1'b0, 4);
    sorter_clr    = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge sys_clk);
    sorter_clr    = 1'b0;
    bus.res_ready = 1'b0;
    check("clr_outputs", {28'd0, bus.res_valid, bus.frame_done, bus.merge_busy, bus.overflow_err}, 32'd0);
    fd_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge sys_clk);
      fd_seen += int'(bus.frame_done) + int'(bus.res_valid);
    end
    check("clr_no_frame_done", fd_seen, 0);
    run_frame(vecs[0], 1'b0);
    check("overflow_after_clr", {31'd0, bus.overflow_err}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
